// File: rtl/pp_pipeline_accel_pkg.sv
// Shared types, constants and output-range helpers for the pp_pipeline accelerator datapath.
package pp_pipeline_accel_pkg;

  localparam int PP_MULADD_LAT = 4;
  localparam int PP_MAX_W      = 128;

  typedef struct packed {
    logic valid;
    logic acc_en;
    logic last;
  } stage_ctl_t;

  // Upper/lower bound of a w-bit result, returned wide enough to compare any accumulator value.
  function automatic logic signed [PP_MAX_W-1:0] range_hi(input int unsigned w, input bit sgn);
    logic signed [PP_MAX_W-1:0] one;
    one = PP_MAX_W'(1);
    return (one << (sgn ? w - 1 : w)) - one;
  endfunction

  function automatic logic signed [PP_MAX_W-1:0] range_lo(input int unsigned w, input bit sgn);
    logic signed [PP_MAX_W-1:0] one;
    one = PP_MAX_W'(1);
    return sgn ? -(one << (w - 1)) : '0;
  endfunction

endpackage

// File: rtl/pp_pipeline_accel_muladd_sat.sv
// Combinational output formatter: flags results outside the OUT_W range and truncates or clamps.
module pp_pipeline_accel_muladd_sat
  import pp_pipeline_accel_pkg::*;
#(
  parameter int ACC_W  = 48,
  parameter int OUT_W  = 21,
  parameter int SIGNED = 0,
  parameter int SAT    = 0
) (
  input  logic [ACC_W-1:0] p,
  output logic [OUT_W-1:0] dout,
  output logic             ovf
);

  localparam bit SGN = (SIGNED != 0);
  localparam logic signed [PP_MAX_W-1:0] HI = range_hi(OUT_W, SGN);
  localparam logic signed [PP_MAX_W-1:0] LO = range_lo(OUT_W, SGN);

  logic signed [PP_MAX_W-1:0] px;
  logic over, under;

  always_comb begin
    if (SGN) px = PP_MAX_W'($signed(p));
    else     px = PP_MAX_W'(p);
    over  = px > HI;
    under = px < LO;
    ovf   = over || under;
    dout  = p[OUT_W-1:0];
    if (SAT != 0) begin
      if (over)       dout = HI[OUT_W-1:0];
      else if (under) dout = LO[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/pp_pipeline_accel_muladd_acc_pipe.sv
// Four-stage multiply-add with optional group accumulation; a single advance enable
// stalls every stage together when the output is held by downstream.
module pp_pipeline_accel_muladd_acc_pipe
  import pp_pipeline_accel_pkg::*;
#(
  parameter int A_W    = 8,
  parameter int B_W    = 13,
  parameter int C_W    = 15,
  parameter int ACC_W  = 48,
  parameter int OUT_W  = 21,
  parameter int SIGNED = 0,
  parameter int SAT    = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [A_W-1:0]   din0,
  input  logic [B_W-1:0]   din1,
  input  logic [C_W-1:0]   din2,
  input  logic             acc_en,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] dout,
  output logic             out_ovf
);

  logic adv, take;
  logic [ACC_W-1:0] a_x, b_x, c_x;
  logic [ACC_W-1:0] a1, b1, c1, m2, c2, p, addend;
  stage_ctl_t ctl1, ctl2;
  logic first, emit3;
  logic [OUT_W-1:0] fmt_dout;
  logic fmt_ovf;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv && !reset;
  assign take     = in_valid && in_ready;

  always_comb begin
    if (SIGNED != 0) begin
      a_x = ACC_W'($signed(din0));
      b_x = ACC_W'($signed(din1));
      c_x = ACC_W'($signed(din2));
    end else begin
      a_x = ACC_W'(din0);
      b_x = ACC_W'(din1);
      c_x = ACC_W'(din2);
    end
  end

  // A standalone beat or the opening beat of a group restarts the sum from c.
  assign addend = (!ctl2.acc_en || first) ? c2 : p;

  always_ff @(posedge clk) begin
    if (reset) begin
      a1        <= '0;
      b1        <= '0;
      c1        <= '0;
      ctl1      <= '0;
      m2        <= '0;
      c2        <= '0;
      ctl2      <= '0;
      p         <= '0;
      first     <= 1'b1;
      emit3     <= 1'b0;
      out_valid <= 1'b0;
      dout      <= '0;
      out_ovf   <= 1'b0;
    end else if (adv) begin
      a1   <= a_x;
      b1   <= b_x;
      c1   <= c_x;
      ctl1 <= '{valid: take, acc_en: acc_en, last: in_last};
      m2   <= a1 * b1;
      c2   <= c1;
      ctl2 <= ctl1;
      if (ctl2.valid) begin
        p     <= m2 + addend;
        first <= !ctl2.acc_en || ctl2.last;
      end
      emit3     <= ctl2.valid && (!ctl2.acc_en || ctl2.last);
      out_valid <= emit3;
      if (emit3) begin
        dout    <= fmt_dout;
        out_ovf <= fmt_ovf;
      end
    end
  end

  pp_pipeline_accel_muladd_sat #(
    .ACC_W (ACC_W),
    .OUT_W (OUT_W),
    .SIGNED(SIGNED),
    .SAT   (SAT)
  ) u_sat (
    .p   (p),
    .dout(fmt_dout),
    .ovf (fmt_ovf)
  );

endmodule
